// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC owner, single-outstanding imem requester, 1-entry skid, IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises if_misaligned and parks fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_if.master     imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              if_misaligned
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t      state, state_d;
    logic [31:0] pc, inflight_pc;
    logic        skid_valid;
    logic [31:0] skid_instr, skid_pc;
    logic [31:0] redirect_tgt;
    logic        bad_tgt, misaligned;
    logic        accept, rsp_take, consume;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_tgt = redirect_pc;
    assign bad_tgt      = |redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misaligned <= 1'b0;
        else if (redirect_valid)
            misaligned <= bad_tgt;
    end

    assign if_misaligned = misaligned;
`else
    assign redirect_tgt = redirect_pc & ~32'h3;
    assign bad_tgt      = 1'b0;
    assign misaligned   = 1'b0;
`endif

    // No new request while the skid is occupied, so a response always has somewhere to land.
    assign imem.imem_req_valid = (state == S_REQ) && !skid_valid && !misaligned;
    assign imem.imem_addr      = pc;

    assign accept   = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_take = (state == S_WAIT) && imem.imem_rsp_valid;
    assign consume  = if_id_valid && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (accept) state_d = redirect_valid ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (imem.imem_rsp_valid)
                    state_d = S_REQ;
                else if (redirect_valid)
                    state_d = S_DROP;
            end
            S_DROP: if (imem.imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight_pc <= 32'h0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'h0;
            if_id_pc4   <= 32'h0;
        end else if (redirect_valid) begin
            // Redirect beats stall and any response; a response racing it is dropped by the FSM.
            pc          <= redirect_tgt;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            skid_valid  <= 1'b0;
            if (bad_tgt)
                if_id_pc <= redirect_pc;
        end else begin
            if (accept) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (consume && skid_valid) begin
                if_id_valid <= 1'b1;
                if_id_instr <= skid_instr;
                if_id_pc    <= skid_pc;
                if_id_pc4   <= skid_pc + 32'd4;
                skid_valid  <= 1'b0;
            end else if (rsp_take && (!if_id_valid || consume)) begin
                if_id_valid <= 1'b1;
                if_id_instr <= imem.imem_rsp_data;
                if_id_pc    <= inflight_pc;
                if_id_pc4   <= inflight_pc + 32'd4;
            end else if (rsp_take) begin
                skid_valid <= 1'b1;
                skid_instr <= imem.imem_rsp_data;
                skid_pc    <= inflight_pc;
            end else if (consume) begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule
